boot_sequencer: RTL and testbench
=================================

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: clk cycles per SCK half-period (range 1..255).
REQ-002 SHALL have parameter GUARD, default 16: consecutive cycles of bootloader CS high required before bus takeover, and idle gap between command bytes.
REQ-003 SHALL have parameter PROG_HOLD, default 256: cycles user_programn is held low.
REQ-004 SHALL have parameter SEND_RESET, default 1: 1 = issue flash reset 0x66/0x99 before programn; 0 = skip the commands.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port boot_req, input, 1: boot request from tinyfpga_bootloader (pulse or level).
REQ-008 SHALL have ports bl_spi_cs, bl_spi_sck, bl_spi_mosi, input, 1 each: bootloader SPI master signals.
REQ-009 SHALL have ports spi_cs, spi_sck, spi_mosi, output, 1 each: flash SPI (CS to flash_csn; SCK to USRMCLK).
REQ-010 SHALL have port busy, output, 1: high from boot_req acceptance until reset.
REQ-011 SHALL have port user_programn, output, 1: active-low FPGA reconfigure request.

Function
REQ-012 SHALL use states IDLE, WAIT_CS, CMD, GAP, PROG, HALT.
REQ-013 In IDLE and WAIT_CS, spi_cs/spi_sck/spi_mosi SHALL combinationally equal bl_spi_cs/bl_spi_sck/bl_spi_mosi (zero-latency passthrough).
REQ-014 In CMD, GAP, PROG and HALT, the sequencer SHALL own the bus; spi_cs = 1 and spi_sck = 0 outside active byte shifts.
REQ-015 IDLE -> WAIT_CS SHALL occur on the first clk edge with boot_req = 1; busy goes high on the same edge.
REQ-016 boot_req SHALL be ignored in every state except IDLE.
REQ-017 WAIT_CS SHALL count consecutive cycles with bl_spi_cs = 1, clearing the count on any cycle with bl_spi_cs = 0; at count = GUARD -> CMD (SEND_RESET = 1) or PROG (SEND_RESET = 0).
REQ-018 CMD SHALL shift one byte in SPI mode 0, MSB first: spi_cs low; each bit drives spi_mosi with spi_sck low for CLK_DIV cycles, then spi_sck high for CLK_DIV cycles; after bit 0, spi_sck low and spi_cs high.
REQ-019 spi_cs SHALL fall at least CLK_DIV cycles before the first SCK rise, and rise no earlier than CLK_DIV cycles after the last SCK fall.
REQ-020 The first CMD byte SHALL be 0x66 and the second 0x99; each is followed by GAP, lasting GUARD cycles with CS high.
REQ-021 GAP after 0x66 SHALL go to CMD; GAP after 0x99 SHALL go to PROG.
REQ-022 PROG SHALL drive user_programn = 0 for exactly PROG_HOLD cycles, then -> HALT.
REQ-023 HALT SHALL be terminal until reset: user_programn = 1, busy = 1, spi_cs = 1, spi_sck = 0.
REQ-024 All counters SHALL be sized for their parameter maximum and SHALL NOT wrap within a state.
REQ-025 If boot_req and bl_spi_cs = 0 occur in the same IDLE cycle, the sequencer SHALL enter WAIT_CS with count 0.

Reset
REQ-026 Asserting reset SHALL force, without waiting for clk: state IDLE, all counters 0, busy = 0, user_programn = 1.
REQ-027 Reset mid-CMD or mid-PROG SHALL abort immediately; user_programn returns to 1 and bus ownership returns to passthrough.
REQ-028 After reset deasserts, the first clk edge SHALL evaluate IDLE normally.

Verification
REQ-029 Idle passthrough: toggle bl_spi_* with boot_req = 0 -> spi_* match every cycle; busy = 0; user_programn = 1.
REQ-030 Full sequence with defaults: boot_req pulse, bl_spi_cs = 1 -> 16 cycles WAIT_CS; decoded MOSI bytes 0x66 then 0x99 at 4 clk per SCK period; 16-cycle gaps; then user_programn low for exactly 256 cycles; then HALT.
REQ-031 Guard restart: bl_spi_cs drops at WAIT_CS count 10 -> count restarts; CS goes low no earlier than 16 cycles after bl_spi_cs returns high.
REQ-032 SEND_RESET = 0 -> no SCK edges; programn falls on the cycle after guard completion, lasting PROG_HOLD.
REQ-033 Reset asserted in the middle of byte 0x99 and during PROG -> immediate IDLE outputs, busy = 0, user_programn = 1; a new boot_req restarts the full sequence.
REQ-034 A second boot_req during CMD/PROG/HALT -> no effect on the sequence or its timing.

Source files
------------

// File: rtl/boot_sequencer.sv
// Boot sequencer: takes the flash SPI bus over from the bootloader, optionally
// resets the flash (0x66 then 0x99), then pulses user_programn to reconfigure.
module boot_sequencer #(
    parameter int CLK_DIV    = 2,
    parameter int GUARD      = 16,
    parameter int PROG_HOLD  = 256,
    parameter int SEND_RESET = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic boot_req,
    input  logic bl_spi_cs,
    input  logic bl_spi_sck,
    input  logic bl_spi_mosi,
    output logic spi_cs,
    output logic spi_sck,
    output logic spi_mosi,
    output logic busy,
    output logic user_programn
);

    localparam int GW = $clog2(GUARD + 1);
    localparam int PW = $clog2(PROG_HOLD + 1);

    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD - 1);
    localparam logic [PW-1:0] PROG_LAST  = PW'(PROG_HOLD - 1);
    localparam logic [7:0]    DIV_LAST   = 8'(CLK_DIV - 1);
    // Halves 0..15 are the low/high SCK phases of bits 7..0; half 16 is the CS hold tail.
    localparam logic [4:0]    HALF_LAST  = 5'd16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_CS = 3'd1,
        CMD     = 3'd2,
        GAP     = 3'd3,
        PROG    = 3'd4,
        HALT    = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   guard_q, guard_d;
    logic [7:0]      div_q, div_d;
    logic [4:0]      half_q, half_d;
    logic            second_q, second_d;
    logic [PW-1:0]   prog_q, prog_d;

    logic [7:0]      cmd_byte;
    logic [2:0]      bit_idx;

    assign cmd_byte = second_q ? 8'h99 : 8'h66;
    assign bit_idx  = 3'd7 - half_q[3:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            guard_q  <= '0;
            div_q    <= '0;
            half_q   <= '0;
            second_q <= 1'b0;
            prog_q   <= '0;
        end else begin
            state_q  <= state_d;
            guard_q  <= guard_d;
            div_q    <= div_d;
            half_q   <= half_d;
            second_q <= second_d;
            prog_q   <= prog_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        guard_d  = guard_q;
        div_d    = div_q;
        half_d   = half_q;
        second_d = second_q;
        prog_d   = prog_q;
        case (state_q)
            IDLE: begin
                // The IDLE cycle never counts toward the guard, whatever bl_spi_cs is.
                guard_d = '0;
                if (boot_req) begin
                    state_d = WAIT_CS;
                end
            end
            WAIT_CS: begin
                if (!bl_spi_cs) begin
                    guard_d = '0;
                end else if (guard_q == GUARD_LAST) begin
                    guard_d  = '0;
                    div_d    = '0;
                    half_d   = '0;
                    second_d = 1'b0;
                    prog_d   = '0;
                    state_d  = (SEND_RESET != 0) ? CMD : PROG;
                end else begin
                    guard_d = guard_q + 1'b1;
                end
            end
            CMD: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (half_q == HALF_LAST) begin
                        half_d  = '0;
                        state_d = GAP;
                    end else begin
                        half_d = half_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            GAP: begin
                if (guard_q == GUARD_LAST) begin
                    guard_d = '0;
                    if (second_q) begin
                        state_d = PROG;
                    end else begin
                        second_d = 1'b1;
                        state_d  = CMD;
                    end
                end else begin
                    guard_d = guard_q + 1'b1;
                end
            end
            PROG: begin
                if (prog_q == PROG_LAST) begin
                    prog_d  = '0;
                    state_d = HALT;
                end else begin
                    prog_d = prog_q + 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        spi_cs        = 1'b1;
        spi_sck       = 1'b0;
        spi_mosi      = 1'b0;
        busy          = 1'b1;
        user_programn = 1'b1;
        case (state_q)
            IDLE: begin
                spi_cs   = bl_spi_cs;
                spi_sck  = bl_spi_sck;
                spi_mosi = bl_spi_mosi;
                busy     = 1'b0;
            end
            WAIT_CS: begin
                spi_cs   = bl_spi_cs;
                spi_sck  = bl_spi_sck;
                spi_mosi = bl_spi_mosi;
            end
            CMD: begin
                spi_cs = 1'b0;
                if (half_q != HALF_LAST) begin
                    spi_sck  = half_q[0];
                    spi_mosi = cmd_byte[bit_idx];
                end
            end
            PROG: begin
                user_programn = 1'b0;
            end
            default: begin
                spi_cs = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_boot_sequencer.sv
// Randomized bench for boot_sequencer: a default instance and a short
// no-flash-reset instance, checked against an expected-waveform model.
`timescale 1ns/1ps
module tb_boot_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic boot = 1'b0;
    logic sel_b = 1'b0;
    logic bl_cs = 1'b1;
    logic bl_sck = 1'b0;
    logic bl_mosi = 1'b0;
    logic boot_a, boot_b;
    logic cs_a, sck_a, mosi_a, busy_a, pn_a;
    logic cs_b, sck_b, mosi_b, busy_b, pn_b;
    logic o_cs, o_sck, o_mosi, o_busy, o_pn;

    assign boot_a = boot & ~sel_b;
    assign boot_b = boot & sel_b;
    assign o_cs   = sel_b ? cs_b   : cs_a;
    assign o_sck  = sel_b ? sck_b  : sck_a;
    assign o_mosi = sel_b ? mosi_b : mosi_a;
    assign o_busy = sel_b ? busy_b : busy_a;
    assign o_pn   = sel_b ? pn_b   : pn_a;

    boot_sequencer u_a (
        .clk(clk), .reset(reset), .boot_req(boot_a),
        .bl_spi_cs(bl_cs), .bl_spi_sck(bl_sck), .bl_spi_mosi(bl_mosi),
        .spi_cs(cs_a), .spi_sck(sck_a), .spi_mosi(mosi_a),
        .busy(busy_a), .user_programn(pn_a)
    );

    boot_sequencer #(.CLK_DIV(3), .GUARD(5), .PROG_HOLD(20), .SEND_RESET(0)) u_b (
        .clk(clk), .reset(reset), .boot_req(boot_b),
        .bl_spi_cs(bl_cs), .bl_spi_sck(bl_sck), .bl_spi_mosi(bl_mosi),
        .spi_cs(cs_b), .spi_sck(sck_b), .spi_mosi(mosi_b),
        .busy(busy_b), .user_programn(pn_b)
    );

    int n_vec = 0;
    int n_err = 0;
    int p_div, p_guard, p_hold, p_send;

    typedef struct {
        logic cs;
        logic sck;
        logic mosi;
        bit   mchk;
        logic pn;
    } exp_t;
    exp_t exp_q[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    function automatic void push_exp(input logic cs, input logic sck, input logic mosi,
                                     input bit mchk, input logic pn);
        exp_t e;
        e.cs = cs; e.sck = sck; e.mosi = mosi; e.mchk = mchk; e.pn = pn;
        exp_q.push_back(e);
    endfunction

    // Expected bus/programn waveform from the first owned cycle onward.
    function automatic void build_expect();
        logic [7:0] cmd;
        exp_q.delete();
        if (p_send != 0) begin
            for (int k = 0; k < 2; k++) begin
                cmd = (k == 0) ? 8'h66 : 8'h99;
                for (int b = 7; b >= 0; b--) begin
                    for (int c = 0; c < p_div; c++) push_exp(1'b0, 1'b0, cmd[b], 1'b1, 1'b1);
                    for (int c = 0; c < p_div; c++) push_exp(1'b0, 1'b1, cmd[b], 1'b1, 1'b1);
                end
                for (int c = 0; c < p_div; c++) push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                for (int c = 0; c < p_guard; c++) push_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            end
        end
        for (int c = 0; c < p_hold; c++) push_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 12; c++) push_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    function automatic void params_a();
        p_div = 2; p_guard = 16; p_hold = 256; p_send = 1;
    endfunction

    task automatic rand_bus();
        bl_sck  = 1'($urandom_range(0, 1));
        bl_mosi = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        boot = 1'b0;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
    endtask

    // One boot attempt: accept, guard (with an optional CS drop), then the owned phase.
    task automatic run_sequence(input int drop_at, input int drop_len, input int abort_at,
                                input logic boot_cs);
        int idx, run, nbits;
        logic prev_sck;
        logic [7:0] sh, want_b;
        logic [7:0] got_bytes[$];
        exp_t e;

        @(posedge clk); #2;
        boot = 1'b1; bl_cs = boot_cs; rand_bus();
        #2;
        n_vec++;
        if ({o_cs, o_sck, o_mosi, o_busy, o_pn} !== {bl_cs, bl_sck, bl_mosi, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL boot_cycle: got %b want %b", {o_cs, o_sck, o_mosi, o_busy, o_pn},
                     {bl_cs, bl_sck, bl_mosi, 1'b0, 1'b1});
        end

        idx = 0; run = 0;
        while (run < p_guard && idx < 200) begin
            @(posedge clk); #2;
            boot = ($urandom_range(0, 3) == 0);
            bl_cs = !(idx >= drop_at && idx < drop_at + drop_len);
            rand_bus();
            #2;
            n_vec++;
            if ({o_cs, o_sck, o_mosi, o_busy, o_pn} !== {bl_cs, bl_sck, bl_mosi, 1'b1, 1'b1}) begin
                n_err++;
                $display("FAIL wait_cs idx %0d: got %b want %b", idx,
                         {o_cs, o_sck, o_mosi, o_busy, o_pn}, {bl_cs, bl_sck, bl_mosi, 1'b1, 1'b1});
            end
            run = bl_cs ? run + 1 : 0;
            idx++;
        end

        build_expect();
        prev_sck = 1'b0; nbits = 0; sh = 8'h00;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #2;
            boot = ($urandom_range(0, 3) == 0);
            bl_cs = 1'($urandom_range(0, 1));
            rand_bus();
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                n_vec++;
                if ({o_cs, o_sck, o_mosi, o_busy, o_pn} !== {bl_cs, bl_sck, bl_mosi, 1'b0, 1'b1}) begin
                    n_err++;
                    $display("FAIL abort_reset at %0d: got %b want %b", i,
                             {o_cs, o_sck, o_mosi, o_busy, o_pn}, {bl_cs, bl_sck, bl_mosi, 1'b0, 1'b1});
                end
                boot = 1'b0;
                @(posedge clk); #2;
                reset = 1'b0;
                rand_bus();
                #2;
                n_vec++;
                if ({o_cs, o_sck, o_mosi, o_busy, o_pn} !== {bl_cs, bl_sck, bl_mosi, 1'b0, 1'b1}) begin
                    n_err++;
                    $display("FAIL post_reset_idle: got %b want %b",
                             {o_cs, o_sck, o_mosi, o_busy, o_pn}, {bl_cs, bl_sck, bl_mosi, 1'b0, 1'b1});
                end
                return;
            end
            #2;
            e = exp_q[i];
            n_vec++;
            if ({o_cs, o_sck, o_busy, o_pn} !== {e.cs, e.sck, 1'b1, e.pn}) begin
                n_err++;
                $display("FAIL owned cyc %0d: got cs/sck/busy/pn %b want %b", i,
                         {o_cs, o_sck, o_busy, o_pn}, {e.cs, e.sck, 1'b1, e.pn});
            end
            if (e.mchk) begin
                n_vec++;
                if (o_mosi !== e.mosi) begin
                    n_err++;
                    $display("FAIL mosi cyc %0d: got %b want %b", i, o_mosi, e.mosi);
                end
            end
            if (o_cs === 1'b0 && o_sck === 1'b1 && prev_sck === 1'b0) begin
                sh = {sh[6:0], o_mosi};
                nbits++;
                if (nbits % 8 == 0) got_bytes.push_back(sh);
            end
            prev_sck = o_sck;
        end
        boot = 1'b0;

        n_vec++;
        if (nbits != 16 * p_send) begin
            n_err++;
            $display("FAIL sck_rises: got %0d want %0d", nbits, 16 * p_send);
        end
        for (int k = 0; k < 2 * p_send; k++) begin
            want_b = (k == 0) ? 8'h66 : 8'h99;
            n_vec++;
            if (k >= got_bytes.size()) begin
                n_err++;
                $display("FAIL decoded_byte %0d: got none want %h", k, want_b);
            end else if (got_bytes[k] !== want_b) begin
                n_err++;
                $display("FAIL decoded_byte %0d: got %h want %h", k, got_bytes[k], want_b);
            end
        end
    endtask

    task automatic test_reset();
        sel_b = 1'b0; boot = 1'b0; reset = 1'b1;
        repeat (3) @(posedge clk);
        #2; bl_cs = 1'($urandom_range(0, 1)); rand_bus(); #2;
        n_vec++;
        if ({cs_a, sck_a, mosi_a, busy_a, pn_a} !== {bl_cs, bl_sck, bl_mosi, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_a: got %b want %b", {cs_a, sck_a, mosi_a, busy_a, pn_a},
                     {bl_cs, bl_sck, bl_mosi, 1'b0, 1'b1});
        end
        n_vec++;
        if ({cs_b, sck_b, mosi_b, busy_b, pn_b} !== {bl_cs, bl_sck, bl_mosi, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_b: got %b want %b", {cs_b, sck_b, mosi_b, busy_b, pn_b},
                     {bl_cs, bl_sck, bl_mosi, 1'b0, 1'b1});
        end
        reset = 1'b0;
    endtask

    task automatic test_passthrough();
        sel_b = 1'b0; boot = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            bl_cs = 1'($urandom_range(0, 1)); rand_bus();
            #2;
            n_vec++;
            if ({o_cs, o_sck, o_mosi, o_busy, o_pn} !== {bl_cs, bl_sck, bl_mosi, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL passthrough cyc %0d: got %b want %b", i,
                         {o_cs, o_sck, o_mosi, o_busy, o_pn}, {bl_cs, bl_sck, bl_mosi, 1'b0, 1'b1});
            end
        end
    endtask

    task automatic test_full_sequence();
        sel_b = 1'b0; params_a();
        run_sequence(1000, 0, -1, 1'b1);
        do_reset();
    endtask

    task automatic test_guard_restart();
        sel_b = 1'b0; params_a();
        run_sequence(10, int'($urandom_range(1, 3)), -1, 1'b0);
        do_reset();
        run_sequence(int'($urandom_range(0, 15)), int'($urandom_range(1, 4)), -1,
                     1'($urandom_range(0, 1)));
        do_reset();
    endtask

    task automatic test_reset_abort();
        int byte2, prog0;
        sel_b = 1'b0; params_a();
        byte2 = 17 * p_div + p_guard;
        prog0 = 2 * byte2;
        run_sequence(1000, 0, byte2 + int'($urandom_range(2, 31)), 1'b1);
        run_sequence(1000, 0, prog0 + int'($urandom_range(1, 250)), 1'b1);
        run_sequence(1000, 0, -1, 1'b1);
        do_reset();
    endtask

    task automatic test_no_send_reset();
        sel_b = 1'b1;
        p_div = 3; p_guard = 5; p_hold = 20; p_send = 0;
        run_sequence(int'($urandom_range(0, 4)), int'($urandom_range(1, 2)), -1, 1'b1);
        do_reset();
        sel_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_full_sequence();
        test_guard_restart();
        test_reset_abort();
        test_no_send_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
